// File: rtl/magma_pkg.sv
// Shared constants, S-box tables and round-key scheduling for the Magma ECB engine.
package magma_pkg;

    localparam logic [4:0]  ROUND_LAST = 5'd31;
    localparam int unsigned ROT        = 11;

    typedef enum logic [0:0] {IDLE, RUN} state_e;

    // pi_i packed with entry j at bits [4j+3:4j]; PI[i] is pi_i
    localparam logic [7:0][63:0] PI = {
        64'h2BC96AF43850DE71,
        64'h73AD0B4FC19652E8,
        64'h0E34187BAC296FD5,
        64'hC24BE390D618A5F7,
        64'hB9E35A076F4D128C,
        64'h069C471EDAF2853B,
        64'hF0DB74E1C5A93286,
        64'h1F307D8E9B5A264C
    };

    function automatic logic [31:0] s_box(input logic [31:0] x);
        logic [31:0] y;
        logic [63:0] tbl;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            tbl          = PI[i];
            y[4*i +: 4]  = tbl[{x[4*i +: 4], 2'b00} +: 4];
        end
        return y;
    endfunction

    // Returns 0-based index into K1..K8
    function automatic logic [2:0] enc_key_idx(input logic [4:0] rnd);
        return (rnd < 5'd24) ? rnd[2:0] : ~rnd[2:0];
    endfunction

    function automatic logic [2:0] dec_key_idx(input logic [4:0] rnd);
        return (rnd < 5'd8) ? rnd[2:0] : ~rnd[2:0];
    endfunction

endpackage

// File: rtl/magma_round.sv
// One combinational Magma round; the final round skips the half swap.
module magma_round
    import magma_pkg::*;
(
    input  logic [63:0] a,
    input  logic [31:0] k,
    input  logic        final_round,
    output logic [63:0] a_next
);

    logic [31:0] a1, a0, sub, g, f;

    assign a1     = a[63:32];
    assign a0     = a[31:0];
    assign sub    = s_box(a0 + k);
    assign g      = (sub << ROT) | (sub >> (32 - ROT));
    assign f      = g ^ a1;
    assign a_next = final_round ? {f, a0} : {a0, f};

endmodule

// File: rtl/magma_ecb_engine.sv
// Iterative Magma ECB engine: one round per clock over BLOCKS 64-bit blocks.
module magma_ecb_engine
    import magma_pkg::*;
#(
    parameter int unsigned ROUNDS = 32,
    parameter int unsigned BLOCKS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  decrypt,
    input  logic [64*BLOCKS-1:0]  data_in,
    input  logic [255:0]          key,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [64*BLOCKS-1:0]  data_out
);

    localparam int unsigned RND_W = $clog2(ROUNDS);
    localparam int unsigned BLK_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCKS - 1);

    state_e                   state_q, state_d;
    logic [RND_W-1:0]         rnd_q, rnd_d;
    logic [BLK_W-1:0]         blk_q, blk_d;
    logic [63:0]              work_q, work_d;
    logic [BLOCKS-1:0][63:0]  snap_q, snap_d;
    logic [7:0][31:0]         snap_key_q, snap_key_d;
    logic                     snap_dec_q, snap_dec_d;
    logic [BLOCKS-1:0][63:0]  res_q, res_d;
    logic [BLOCKS-1:0][63:0]  dout_q, dout_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     valid_q, valid_d;

    logic [2:0]  kidx;
    logic [31:0] round_key;
    logic [63:0] round_out;
    logic        last_round;

    assign last_round = (rnd_q == ROUND_LAST);
    assign kidx       = snap_dec_q ? dec_key_idx(rnd_q) : enc_key_idx(rnd_q);
    // key[255:224] is K1, i.e. packed word 7
    assign round_key  = snap_key_q[~kidx];

    magma_round u_round (
        .a           (work_q),
        .k           (round_key),
        .final_round (last_round),
        .a_next      (round_out)
    );

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        blk_d      = blk_q;
        work_d     = work_q;
        snap_d     = snap_q;
        snap_key_d = snap_key_q;
        snap_dec_d = snap_dec_q;
        res_d      = res_q;
        dout_d     = dout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d     = data_in;
                    snap_key_d = key;
                    snap_dec_d = decrypt;
                    work_d     = data_in[63:0];
                    rnd_d      = '0;
                    blk_d      = '0;
                    busy_d     = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                work_d = round_out;
                rnd_d  = rnd_q + 1'b1;
                if (last_round) begin
                    res_d[blk_q] = round_out;
                    if (blk_q != BLK_LAST) begin
                        work_d = snap_q[blk_q + 1'b1];
                        blk_d  = blk_q + 1'b1;
                        rnd_d  = '0;
                    end else begin
                        dout_d  = res_d;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rnd_q      <= '0;
            blk_q      <= '0;
            work_q     <= '0;
            snap_q     <= '0;
            snap_key_q <= '0;
            snap_dec_q <= 1'b0;
            res_q      <= '0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            blk_q      <= blk_d;
            work_q     <= work_d;
            snap_q     <= snap_d;
            snap_key_q <= snap_key_d;
            snap_dec_q <= snap_dec_d;
            res_q      <= res_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign data_out  = dout_q;

endmodule

// File: tb/tb_magma_ecb_engine.sv
// Self-checking bench for magma_ecb_engine against a transaction-level Magma model.
module tb_magma_ecb_engine;

    localparam logic [255:0] KEY =
        256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0] PT = 64'hfedcba9876543210;
    localparam logic [63:0] CT = 64'h4ee901e5c2d8ca3d;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         decrypt = 1'b0;
    logic [127:0] data_in = '0;
    logic [255:0] key = '0;
    logic         busy, done, out_valid;
    logic [127:0] data_out;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    magma_ecb_engine #(
        .ROUNDS (32),
        .BLOCKS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .decrypt   (decrypt),
        .data_in   (data_in),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    // S-box tables pi_0..pi_7 in the order the standard lists them
    int PI_TBL [8][16] = '{
        '{'hC, 'h4, 'h6, 'h2, 'hA, 'h5, 'hB, 'h9, 'hE, 'h8, 'hD, 'h7, 'h0, 'h3, 'hF, 'h1},
        '{'h6, 'h8, 'h2, 'h3, 'h9, 'hA, 'h5, 'hC, 'h1, 'hE, 'h4, 'h7, 'hB, 'hD, 'h0, 'hF},
        '{'hB, 'h3, 'h5, 'h8, 'h2, 'hF, 'hA, 'hD, 'hE, 'h1, 'h7, 'h4, 'hC, 'h9, 'h6, 'h0},
        '{'hC, 'h8, 'h2, 'h1, 'hD, 'h4, 'hF, 'h6, 'h7, 'h0, 'hA, 'h5, 'h3, 'hE, 'h9, 'hB},
        '{'h7, 'hF, 'h5, 'hA, 'h8, 'h1, 'h6, 'hD, 'h0, 'h9, 'h3, 'hE, 'hB, 'h4, 'h2, 'hC},
        '{'h5, 'hD, 'hF, 'h6, 'h9, 'h2, 'hC, 'hA, 'hB, 'h7, 'h8, 'h1, 'h4, 'h3, 'hE, 'h0},
        '{'h8, 'hE, 'h2, 'h5, 'h6, 'h9, 'h1, 'hC, 'hF, 'h4, 'hB, 'h0, 'hD, 'hA, 'h3, 'h7},
        '{'h1, 'h7, 'hE, 'hD, 'h0, 'h5, 'h8, 'h3, 'h4, 'hF, 'hA, 'h6, 'h9, 'hC, 'hB, 'h2}
    };

    function automatic logic [31:0] m_g(input logic [31:0] k, input logic [31:0] x);
        logic [31:0] t, s;
        t = x + k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s | (32'(PI_TBL[i][(t >> (4 * i)) & 32'hF]) << (4 * i));
        end
        return (s << 11) | (s >> 21);
    endfunction

    // Encrypt schedule K1..K8 x3 then K8..K1; decrypt uses it reversed
    function automatic logic [63:0] m_block(input logic [63:0] blk, input logic [255:0] kk,
                                            input logic dec);
        logic [31:0] kw [8];
        logic [31:0] enc_s [32];
        logic [31:0] sched [32];
        logic [31:0] a1, a0, t;
        for (int i = 0; i < 8; i++) kw[i] = kk[255 - 32 * i -: 32];
        for (int i = 0; i < 32; i++) enc_s[i] = (i < 24) ? kw[i % 8] : kw[31 - i];
        for (int i = 0; i < 32; i++) sched[i] = dec ? enc_s[31 - i] : enc_s[i];
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int i = 0; i < 31; i++) begin
            t  = m_g(sched[i], a0) ^ a1;
            a1 = a0;
            a0 = t;
        end
        a1 = m_g(sched[31], a0) ^ a1;
        return {a1, a0};
    endfunction

    function automatic logic [127:0] m_word(input logic [127:0] d, input logic [255:0] kk,
                                            input logic dec);
        return {m_block(d[127:64], kk, dec), m_block(d[63:0], kk, dec)};
    endfunction

    // Transaction-level model: accepted start -> result appears 64 edges later
    logic         m_busy, m_done, m_valid;
    logic [127:0] m_dout, m_pend;
    int           m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_valid <= 1'b0;
            m_dout  <= '0;
            m_pend  <= '0;
            m_cnt   <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_pend  <= m_word(data_in, key, decrypt);
                    m_busy  <= 1'b1;
                    m_cnt   <= 64;
                    m_valid <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_valid <= 1'b1;
                    m_dout  <= m_pend;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 128'(busy), 128'(m_busy));
            check("done", 128'(done), 128'(m_done));
            check("out_valid", 128'(out_valid), 128'(m_valid));
            check("data_out", data_out, m_dout);
            if (done) done_cnt++;
        end
    end

    // Caller sits at a negedge; returns at the negedge where done is visible
    task automatic run_op(input logic [127:0] d, input logic dec, input int poke_at,
                          input logic [127:0] poke, output int lat);
        data_in = d;
        decrypt = dec;
        start   = 1'b1;
        lat     = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == poke_at) begin
                data_in = poke;
                start   = 1'b1;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    initial begin
        int           lat;
        int           dc;
        logic [127:0] saved, d, r;
        logic         dec;

        // Model pins against the standard's worked examples
        check("pin_g", 128'(m_g(32'h87654321, 32'hfedcba98)), 128'(32'hfdcbc20c));
        check("pin_enc", 128'(m_block(PT, KEY, 1'b0)), 128'(CT));
        check("pin_dec", 128'(m_block(CT, KEY, 1'b1)), 128'(PT));

        repeat (3) @(negedge clk);
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_valid", 128'(out_valid), 128'(0));
        check("rst_data", data_out, 128'(0));
        reset = 1'b0;
        key   = KEY;
        @(negedge clk);

        // Encrypt known vector in both blocks
        run_op({PT, PT}, 1'b0, -1, '0, lat);
        check("enc_latency", 128'(lat), 128'(64));
        check("enc_data", data_out, {CT, CT});
        check("enc_valid", 128'(out_valid), 128'(1));

        // Decrypt; lower block is decryption of zero
        @(negedge clk);
        run_op({CT, 64'h0}, 1'b1, -1, '0, lat);
        check("dec_hi", 128'(data_out[127:64]), 128'(PT));
        check("dec_lo", 128'(data_out[63:0]), 128'(m_block(64'h0, KEY, 1'b1)));

        // Block independence
        @(negedge clk);
        run_op({64'h0, PT}, 1'b0, -1, '0, lat);
        check("ind_lo", 128'(data_out[63:0]), 128'(CT));
        check("ind_hi", 128'(data_out[127:64]), 128'(m_block(64'h0, KEY, 1'b0)));

        // Start while busy is ignored; single done pulse
        @(negedge clk);
        dc = done_cnt;
        run_op({PT, 64'h0123456789abcdef}, 1'b0, 10, {64'h1111, 64'h2222}, lat);
        repeat (70) @(negedge clk);
        check("busy_ign_data", data_out, m_word({PT, 64'h0123456789abcdef}, KEY, 1'b0));
        check("busy_ign_pulses", 128'(done_cnt - dc), 128'(1));

        // Start in the done cycle
        @(negedge clk);
        run_op({CT, CT}, 1'b1, -1, '0, lat);
        run_op({PT, CT}, 1'b0, -1, '0, lat);
        check("b2b_latency", 128'(lat), 128'(64));
        check("b2b_data", data_out, {CT, m_block(CT, KEY, 1'b0)});

        // Reset mid-run
        @(negedge clk);
        data_in = {PT, PT};
        decrypt = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (39) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_done", 128'(done), 128'(0));
        check("arst_valid", 128'(out_valid), 128'(0));
        check("arst_data", data_out, 128'(0));
        @(negedge clk);
        #1 reset = 1'b0;
        dc = done_cnt;
        repeat (80) @(negedge clk);
        check("arst_no_done", 128'(done_cnt - dc), 128'(0));
        run_op({PT, PT}, 1'b0, -1, '0, lat);
        check("arst_after", data_out, {CT, CT});

        // Hold with toggling inputs
        saved = data_out;
        repeat (100) begin
            @(negedge clk);
            data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            key     = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
        end
        check("hold_data", data_out, saved);
        check("hold_valid", 128'(out_valid), 128'(1));

        // Random operations with encrypt/decrypt round trip
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            key = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
            d   = {$urandom(), $urandom(), $urandom(), $urandom()};
            dec = 1'($urandom_range(0, 1));
            run_op(d, dec, -1, '0, lat);
            check("rnd_latency", 128'(lat), 128'(64));
            check("rnd_data", data_out, m_word(d, key, dec));
            r = data_out;
            @(negedge clk);
            run_op(r, ~dec, -1, '0, lat);
            check("rnd_roundtrip", data_out, d);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/magma_ecb_engine.md
Name: magma_ecb_engine

Overview:
- Magma (GOST R 34.12-2015, 64-bit block, 256-bit key) cipher engine, ECB mode.
- Sits directly downstream of the front-panel data/key entry stage.
- Takes that stage's 128-bit data register and the key, encrypts or decrypts it as two 64-bit blocks, and returns a 128-bit result register for the display path.
- Iterative datapath: one round per clock.

Parameters:
ROUNDS, 32, rounds per block; fixed by the standard, exposed only for the bench.
BLOCKS, 2, number of 64-bit blocks per data word; data width = 64*BLOCKS.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  single-cycle request; sampled only in IDLE
decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with start
data_in  in  128  input word; block0 = [63:0], block1 = [127:64]
key  in  256  cipher key; K1 = key[255:224] ... K8 = key[31:0]
busy  out  1  high while a word is being processed
done  out  1  one-cycle pulse when data_out is updated
out_valid  out  1  high from done until the next accepted start or reset
data_out  out  128  result word; same block layout as data_in; held between operations

Behaviour:
- Reset (async): state = IDLE; busy, done, out_valid = 0; data_out = 0; round counter, block index and snapshot registers = 0.
- States:
  - IDLE: start = 1 on an edge latches data_in, key and decrypt into snapshot registers. Also sets rnd = 0, blk = 0, busy = 1, out_valid = 0, and state = RUN.
  - RUN: each edge applies round rnd to the working block (a1 = [63:32], a0 = [31:0]).
    - Rounds 0..30: (a1, a0) <- (a0, g(a0) ^ a1).
    - Round 31: final transform (a1, a0) <- (g(a0) ^ a1, a0), with no swap.
  - At rnd = 31 the result goes to result[blk].
    - If blk < BLOCKS-1: load the next snapshot block, blk++, rnd = 0.
    - Else, on the same edge: data_out <= full result, done = 1, out_valid = 1, busy = 0, state = IDLE.
- g(x) = rotl11(S(x + k mod 2^32)). S maps nibble i (bits 4i+3:4i) through pi_i of the standard S-box set.
- Round-key order, as indices into K1..K8:
  - Encrypt: rounds 0-23 use K[(rnd mod 8)+1]; rounds 24-31 use K[8-(rnd-24)].
  - Decrypt: rounds 0-7 use K[rnd+1]; rounds 8-31 use K[8-(rnd mod 8)].
- All 32-bit additions wrap modulo 2^32.
- Latency: start sampled at edge E0; rounds occupy E1..E64; done is high for the cycle after E64. Total latency is 64 clocks, fixed and independent of data.
- start while busy: ignored; snapshot is unaffected.
- start on the cycle done is high: accepted, because state is already IDLE. done drops and out_valid clears on that edge.
- data_in and key changing during RUN: no effect, because snapshots are used.
- reset mid-RUN: immediate return to the reset values; the partial result is discarded; no done pulse.
- done is a pulse: high for exactly one cycle per completed operation.

Decomposition:
- Package magma_pkg holds:
  - the eight 16-entry 4-bit S-box tables pi_0..pi_7 (GOST R 34.12-2015);
  - round-key index functions for encrypt and decrypt;
  - state enum {IDLE, RUN};
  - constants ROUND_LAST = 31 and ROT = 11.
- One sub-module: magma_round. It is purely combinational and takes a (64), k (32) and final_round (1), returning the next a.
- The FSM, counters, snapshot registers and output registers stay in magma_ecb_engine.

Test Plan:
1. Encrypt: key = ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data_in = {fedcba9876543210, fedcba9876543210}, start -> done exactly 64 clocks later; data_out = {4ee901e5c2d8ca3d, 4ee901e5c2d8ca3d}; out_valid = 1.
2. Decrypt: same key, data_in = {4ee901e5c2d8ca3d, 0000000000000000}, decrypt = 1 -> data_out[127:64] = fedcba9876543210. data_out[63:0] equals the decryption of zero, checked against the bench model.
3. Block independence: block0 = fedcba9876543210, block1 = 0 -> data_out[63:0] = 4ee901e5c2d8ca3d; upper half matches the model.
4. Busy rules:
   - A start pulse at clock 10 of RUN with a different data_in -> ignored; result equals the first word's result; a single done pulse.
   - A start in the done cycle -> new operation; done again 64 clocks later.
5. Reset at round 40 -> busy, done, out_valid = 0 and data_out = 0 immediately, asynchronous within the cycle; no done pulse follows. A following start gives the correct result.
6. Hold: after done, 100 idle cycles with data_in and key toggling -> data_out is unchanged; out_valid stays 1 until the next start.
